// File: rtl/cfg_dprio_csr_chain_ctrl_if.sv
// ----------------------------------------------------------------------------
// cfg_dprio_csr_chain_ctrl_if
//   Bundles the serial chain, commit/capture controls and the configuration and
//   status buses of one DPRIO CSR chain segment.
//   master : drives the chain inputs (predecessor segment / test controller)
//   slave  : the chain segment itself
//   Signals:
//     i_csr_in, i_csr_en, i_scan_shift_n  serial data, shift enable, ATPG gate
//     i_csr_load, i_csr_capture           commit request, status capture
//     i_status_in[TW]                     readback data
//     o_csr_reg[TW]                       committed configuration
//     o_csr_out                           serial data out
//     o_csr_commit_ok, o_csr_len_err, o_csr_par_err  commit result flags
// ----------------------------------------------------------------------------
interface cfg_dprio_csr_chain_ctrl_if #(
    parameter int unsigned TW = 32
) ();
    logic          i_csr_in;
    logic          i_csr_en;
    logic          i_scan_shift_n;
    logic          i_csr_load;
    logic          i_csr_capture;
    logic [TW-1:0] i_status_in;
    logic [TW-1:0] o_csr_reg;
    logic          o_csr_out;
    logic          o_csr_commit_ok;
    logic          o_csr_len_err;
    logic          o_csr_par_err;

    modport master (
        output i_csr_in, i_csr_en, i_scan_shift_n, i_csr_load, i_csr_capture, i_status_in,
        input  o_csr_reg, o_csr_out, o_csr_commit_ok, o_csr_len_err, o_csr_par_err
    );

    modport slave (
        input  i_csr_in, i_csr_en, i_scan_shift_n, i_csr_load, i_csr_capture, i_status_in,
        output o_csr_reg, o_csr_out, o_csr_commit_ok, o_csr_len_err, o_csr_par_err
    );
endinterface

// File: rtl/cfg_dprio_csr_chain_ctrl.sv
// ----------------------------------------------------------------------------
// cfg_dprio_csr_chain_ctrl
//   Serial CSR chain segment with a shadow register. Bits shift LSB-first
//   through an L-bit chain (TW data bits plus an optional even-parity bit).
//   The configuration register is only updated by a commit whose shift count
//   equals L and whose parity is even. A capture loads status into the chain
//   for serial readback.
//   Ports:
//     i_clk    clock
//     i_rst_n  asynchronous active-low reset
//     bus      cfg_dprio_csr_chain_ctrl_if.slave (serial chain, controls, buses)
// ----------------------------------------------------------------------------
module cfg_dprio_csr_chain_ctrl #(
    parameter int unsigned                    DATA_WIDTH        = 16,
    parameter int unsigned                    NUM_REGS          = 2,
    parameter int unsigned                    PARITY_EN         = 1,
    parameter logic [DATA_WIDTH*NUM_REGS-1:0] RESET_VAL         = '0,
    parameter int unsigned                    CSR_OUT_NEG_FF_EN = 0
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    cfg_dprio_csr_chain_ctrl_if.slave     bus
);
    localparam int unsigned TW = DATA_WIDTH * NUM_REGS;
    localparam int unsigned L  = TW + PARITY_EN;
    localparam int unsigned CW = $clog2(L + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(L);
    localparam logic [CW-1:0] CNT_SAT  = CW'(L + 1);

    logic [L-1:0]  r_sh,  w_sh_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [TW-1:0] r_reg, w_reg_nxt;
    logic          r_ok,  w_ok_nxt;
    logic          r_len, w_len_nxt;
    logic          r_par, w_par_nxt;

    logic w_en;
    logic w_attempt;
    logic w_capture;
    logic w_len_ok;
    logic w_par_ok;

    assign w_en      = bus.i_csr_en & bus.i_scan_shift_n;
    assign w_attempt = bus.i_csr_load & ~w_en;
    assign w_capture = bus.i_csr_capture & ~w_en;
    assign w_len_ok  = (r_cnt == CNT_FULL);
    assign w_par_ok  = (PARITY_EN == 0) || (^r_sh == 1'b0);

    always_comb begin
        w_sh_nxt  = r_sh;
        w_cnt_nxt = r_cnt;
        w_reg_nxt = r_reg;
        w_ok_nxt  = 1'b0;
        w_len_nxt = r_len;
        w_par_nxt = r_par;

        if (w_en) begin
            w_sh_nxt = {bus.i_csr_in, r_sh[L-1:1]};
            if (r_cnt != CNT_SAT) begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end else begin
            // Commit judges the pre-capture chain; a simultaneous capture
            // overwrites the chain on the same edge.
            if (w_attempt) begin
                w_len_nxt = ~w_len_ok;
                w_par_nxt = w_len_ok & ~w_par_ok;
                if (w_len_ok && w_par_ok) begin
                    w_reg_nxt = r_sh[TW-1:0];
                    w_ok_nxt  = 1'b1;
                end
                w_cnt_nxt = '0;
            end
            if (w_capture) begin
                w_sh_nxt[TW-1:0] = bus.i_status_in;
                if (PARITY_EN != 0) begin
                    w_sh_nxt[L-1] = ^bus.i_status_in;
                end
                w_cnt_nxt = '0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sh  <= '0;
            r_cnt <= '0;
            r_reg <= RESET_VAL;
            r_ok  <= 1'b0;
            r_len <= 1'b0;
            r_par <= 1'b0;
        end else begin
            r_sh  <= w_sh_nxt;
            r_cnt <= w_cnt_nxt;
            r_reg <= w_reg_nxt;
            r_ok  <= w_ok_nxt;
            r_len <= w_len_nxt;
            r_par <= w_par_nxt;
        end
    end

    assign bus.o_csr_reg       = r_reg;
    assign bus.o_csr_commit_ok = r_ok;
    assign bus.o_csr_len_err   = r_len;
    assign bus.o_csr_par_err   = r_par;

    generate
        if (CSR_OUT_NEG_FF_EN != 0) begin : g_neg_out
            logic r_neg_ff;
            // Half-cycle retiming for hold margin to the next segment; bypassed
            // while ATPG shifting so scan sees the raw chain bit.
            always_ff @(negedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_neg_ff <= 1'b0;
                end else begin
                    r_neg_ff <= r_sh[0];
                end
            end
            assign bus.o_csr_out = bus.i_scan_shift_n ? r_neg_ff : r_sh[0];
        end else begin : g_pos_out
            assign bus.o_csr_out = r_sh[0];
        end
    endgenerate

endmodule

// File: tb/tb_cfg_dprio_csr_chain_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cfg_dprio_csr_chain_ctrl
//   Scoreboard bench for cfg_dprio_csr_chain_ctrl (8x2, parity on, reset value
//   16'h5A5A). Expected values are queued when stimulus is applied and popped
//   when the DUT result is sampled, 1 time unit after the rising edge.
// ----------------------------------------------------------------------------
module tb_cfg_dprio_csr_chain_ctrl;
    logic clk;
    logic rst_n;

    int unsigned n_total;
    int unsigned n_bad;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    exp_t exp_q[$];

    cfg_dprio_csr_chain_ctrl_if #(.TW(16)) bus ();

    cfg_dprio_csr_chain_ctrl #(
        .DATA_WIDTH        (8),
        .NUM_REGS          (2),
        .PARITY_EN         (1),
        .RESET_VAL         (16'h5A5A),
        .CSR_OUT_NEG_FF_EN (0)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [15:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic pop_chk(input logic [15:0] obs);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 16'(exp_q.size()), 16'd1);
        end else begin
            e = exp_q.pop_front();
            chk(e.tag, obs, e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input logic [15:0] e_reg);
        push("rst_reg", e_reg);
        push("rst_out", 16'd0);
        push("rst_ok",  16'd0);
        push("rst_len", 16'd0);
        push("rst_par", 16'd0);
        pop_chk(bus.o_csr_reg);
        pop_chk(16'(bus.o_csr_out));
        pop_chk(16'(bus.o_csr_commit_ok));
        pop_chk(16'(bus.o_csr_len_err));
        pop_chk(16'(bus.o_csr_par_err));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        check_idle(16'h5A5A);
        rst_n = 1'b1;
        tick();
    endtask

    // Shift n bits of 'bits' LSB first; optionally check the readback stream
    // rb and that the error flags hold while csr_load is high during shifting.
    task automatic shift_n(input logic [31:0] bits, input int unsigned n,
                           input logic rd, input logic [16:0] rb, input logic flg);
        for (int unsigned i = 0; i < n; i++) begin
            if (rd) begin
                push("rb_out", 16'(rb[i]));
                pop_chk(16'(bus.o_csr_out));
            end
            bus.i_csr_en = 1'b1;
            bus.i_csr_in = bits[i];
            tick();
            if (flg) begin
                push("hold_len", 16'd1);
                push("hold_par", 16'd0);
                push("hold_ok",  16'd0);
                pop_chk(16'(bus.o_csr_len_err));
                pop_chk(16'(bus.o_csr_par_err));
                pop_chk(16'(bus.o_csr_commit_ok));
            end
        end
        bus.i_csr_en = 1'b0;
        bus.i_csr_in = 1'b0;
    endtask

    task automatic commit(input logic [15:0] e_reg, input logic e_ok, input logic e_len,
                          input logic e_par, input logic cap, input logic [15:0] st);
        push("cm_reg", e_reg);
        push("cm_ok",  16'(e_ok));
        push("cm_len", 16'(e_len));
        push("cm_par", 16'(e_par));
        if (cap) push("cap_out", 16'(st[0]));
        bus.i_csr_load    = 1'b1;
        bus.i_csr_capture = cap;
        bus.i_status_in   = st;
        tick();
        bus.i_csr_load    = 1'b0;
        bus.i_csr_capture = 1'b0;
        pop_chk(bus.o_csr_reg);
        pop_chk(16'(bus.o_csr_commit_ok));
        pop_chk(16'(bus.o_csr_len_err));
        pop_chk(16'(bus.o_csr_par_err));
        if (cap) pop_chk(16'(bus.o_csr_out));
        if (e_ok) begin
            push("ok_fall", 16'd0);
            tick();
            pop_chk(16'(bus.o_csr_commit_ok));
        end
    endtask

    task automatic capture(input logic [15:0] st);
        push("cap_out", 16'(st[0]));
        bus.i_csr_capture = 1'b1;
        bus.i_status_in   = st;
        tick();
        bus.i_csr_capture = 1'b0;
        pop_chk(16'(bus.o_csr_out));
    endtask

    function automatic logic [31:0] word17(input logic [15:0] d, input logic p);
        return {15'd0, p, d};
    endfunction

    initial begin
        logic [15:0] st;
        n_total = 0;
        n_bad   = 0;
        rst_n = 1'b0;
        bus.i_csr_in       = 1'b0;
        bus.i_csr_en       = 1'b0;
        bus.i_scan_shift_n = 1'b1;
        bus.i_csr_load     = 1'b0;
        bus.i_csr_capture  = 1'b0;
        bus.i_status_in    = '0;

        // 1: correct commit
        do_reset();
        shift_n(word17(16'hA5C3, 1'b0), 17, 1'b0, '0, 1'b0);
        commit(16'hA5C3, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);

        // 2: short shift
        do_reset();
        shift_n(32'h0000_00FF, 16, 1'b0, '0, 1'b0);
        commit(16'h5A5A, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);

        // 3: over-shift (counter saturates), then bad parity
        shift_n(32'h0, 18, 1'b0, '0, 1'b0);
        commit(16'h5A5A, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        shift_n(word17(16'hA5C3, 1'b1), 17, 1'b0, '0, 1'b0);
        commit(16'h5A5A, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);

        // 4: capture readback while shifting in new data, then commit+capture
        st = 16'h1234;
        capture(st);
        shift_n(word17(16'h3C69, 1'b0), 17, 1'b1, {^st, st}, 1'b0);
        commit(16'h3C69, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0F0E);
        // back-to-back attempt sees a cleared counter
        commit(16'h3C69, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);

        // 5: scan gating leaves chain and counter alone
        bus.i_scan_shift_n = 1'b0;
        bus.i_csr_en       = 1'b1;
        bus.i_csr_in       = 1'b1;
        for (int unsigned i = 0; i < 5; i++) begin
            tick();
            push("gate_out", 16'd0);
            pop_chk(16'(bus.o_csr_out));
        end
        bus.i_scan_shift_n = 1'b1;
        bus.i_csr_en       = 1'b0;
        bus.i_csr_in       = 1'b0;
        st = 16'h0F0E;
        bus.i_csr_load = 1'b1;
        shift_n(word17(16'hD2B4, 1'b0), 17, 1'b1, {^st, st}, 1'b1);
        bus.i_csr_load = 1'b0;
        commit(16'hD2B4, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);

        // 6: asynchronous reset in the middle of a shift
        shift_n(32'h1FF, 9, 1'b0, '0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check_idle(16'h5A5A);
        #2;
        rst_n = 1'b1;
        tick();
        shift_n(word17(16'hA5C3, 1'b0), 17, 1'b0, '0, 1'b0);
        commit(16'hA5C3, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);

        chk("sb_drained", 16'(exp_q.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
